instr_fetch: RTL

Instruction fetch stage for the RV32I pipeline: generates sequential word-aligned PCs, issues requests to instruction memory, buffers in-order responses in a small FIFO, and presents them to decode over a valid/ready handshake. Each delivered word is tagged with its PC and an `unsupported` flag when its opcode is neither OP (7'b0110011) nor OP_IMM (7'b0010011). A redirect, such as a branch or jump from a later stage, flushes buffered and in-flight instructions and restarts fetch at a new PC.

---
 rtl/instr_fetch.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I instruction fetch stage with response FIFO and redirect flush
//
// Purpose:
//   Issues sequential word-aligned fetches to instruction memory and tags each
//   in-order response with its PC. Tagged words are buffered in a DEPTH-entry
//   FIFO and handed to decode over a valid/ready handshake. Each word carries a
//   flag that is set when its opcode is neither OP nor OP_IMM. A redirect flushes
//   the FIFO, marks every in-flight response for discard, and restarts fetch at
//   the new PC.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req_*        fetch request: valid/addr out, ready in
//   imem_rsp_*        in-order fetch response: valid/data in (never backpressured)
//   id_*              decode side: valid/instr/pc/unsupported out, ready in
//   redirect_*        flush and restart fetch at redirect_pc (low two bits dropped)

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_unsupported,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  // Discarded responses are not bounded by the FIFO size, so the outstanding
  // counter gets headroom beyond DEPTH and fetch pauses if it ever saturates.
  localparam int unsigned OUT_MAX = 4 * DEPTH;
  localparam int unsigned OW      = $clog2(OUT_MAX + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [AW-1:0] pq_wr_q, pq_wr_d;
  logic [AW-1:0] pq_rd_q, pq_rd_d;

  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_instr_d [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_pc_d    [DEPTH];
  logic [31:0] pq_pc_q      [DEPTH];
  logic [31:0] pq_pc_d      [DEPTH];

  logic          pop;
  logic          req_fire;
  logic          rsp_keep;
  logic [OW-1:0] live;
  logic [OW:0]   occ;
  logic [31:0]   head_instr;
  logic [6:0]    head_opc;

  // Decode-side view of the FIFO head; outputs read zero while empty.
  always_comb begin
    id_valid       = (count_q != '0);
    head_instr     = fifo_instr_q[rd_q];
    head_opc       = head_instr[6:0];
    id_instr       = id_valid ? head_instr : 32'h0;
    id_pc          = id_valid ? fifo_pc_q[rd_q] : 32'h0;
    id_unsupported = id_valid && (head_opc != OPC_OP) && (head_opc != OPC_OP_IMM);
  end

  always_comb begin
    pop  = id_valid && id_ready;
    live = outstanding_q - discard_q;
    // Slots already claimed: buffered words plus live in-flight requests. A
    // head being consumed this cycle frees its slot before any new response
    // can land, which is what lets L=1 sustain one instruction per cycle.
    occ  = (OW + 1)'(count_q) + {1'b0, live} - (OW + 1)'(pop);

    imem_req_valid = rst_n && !redirect_valid
                     && (outstanding_q < OW'(OUT_MAX))
                     && (occ < (OW + 1)'(DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = 1'b0;

    pc_d          = pc_q;
    count_d       = count_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    pq_wr_d       = pq_wr_q;
    pq_rd_d       = pq_rd_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    pq_pc_d       = pq_pc_q;

    if (redirect_valid) begin
      // Everything in flight, minus a response landing right now (which is
      // dropped too), is still owed by memory and must be thrown away.
      count_d       = '0;
      wr_d          = '0;
      rd_d          = '0;
      outstanding_d = outstanding_q - OW'(imem_rsp_valid);
      discard_d     = outstanding_q - OW'(imem_rsp_valid);
      // The PC queue only tracks live requests; owed responses bypass it.
      pq_wr_d       = '0;
      pq_rd_d       = '0;
      pc_d          = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (req_fire) begin
        pc_d             = pc_q + 32'd4;
        pq_pc_d[pq_wr_q] = pc_q;
        pq_wr_d          = pq_wr_q + AW'(1);
      end

      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OW'(1);
        end else begin
          rsp_keep            = 1'b1;
          fifo_instr_d[wr_q]  = imem_rsp_data;
          fifo_pc_d[wr_q]     = pq_pc_q[pq_rd_q];
          wr_d                = wr_q + AW'(1);
          pq_rd_d             = pq_rd_q + AW'(1);
        end
      end

      if (pop) begin
        rd_d = rd_q + AW'(1);
      end

      outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);
      count_d       = count_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      pq_wr_q       <= '0;
      pq_rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0;
        fifo_pc_q[i]    <= 32'h0;
        pq_pc_q[i]      <= 32'h0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pq_wr_q       <= pq_wr_d;
      pq_rd_q       <= pq_rd_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      pq_pc_q       <= pq_pc_d;
    end
  end

endmodule
